// File: rtl/dmem_loader_if.sv
// Byte-stream and data-memory write bundle between the host link, the loader and D_Memory.
// slave is the loader side; master is the host/memory side.
interface dmem_loader_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_loader.sv
// Packs an MSB-first byte stream into 32-bit words, writes matrix1 then matrix2 from
// address 0, holds the CPU in reset until the image is complete, then waits for cpu_done.
module dmem_loader #(
  parameter int M      = 100,
  parameter int N      = 50,
  parameter int N2     = 2,
  parameter int ADDR_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              start,
  dmem_loader_if.slave      bus,
  output logic              cpu_rstn,
  input  logic              cpu_done,
  output logic              load_done,
  output logic              run_done,
  output logic [ADDR_W-1:0] word_count,
  output logic [31:0]       checksum
);

  localparam int WORDS = M * N + N * N2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [23:0]       word_r;
  logic [1:0]        byte_cnt_r;
  logic              in_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              cpu_rstn_r;
  logic              load_done_r;
  logic              run_done_r;
  logic [ADDR_W-1:0] word_count_r;
  logic [31:0]       checksum_r;
  logic              accept_s;
  logic              last_wr_s;

  // in_ready_r is only ever high in LOAD, so this also gates bytes outside LOAD
  assign accept_s  = bus.in_valid && in_ready_r;
  assign last_wr_s = mem_we_r && (word_count_r == LAST_ADDR);

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = LOAD;
        else       state_s = IDLE;
      end
      LOAD: begin
        if (last_wr_s) state_s = RUN;
        else           state_s = LOAD;
      end
      RUN: begin
        if (cpu_done) state_s = DONE;
        else          state_s = RUN;
      end
      DONE:    state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Byte packing, memory write strobe, counters and status flags
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      word_r       <= 24'h00_0000;
      byte_cnt_r   <= 2'd0;
      in_ready_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      cpu_rstn_r   <= 1'b0;
      load_done_r  <= 1'b0;
      run_done_r   <= 1'b0;
      word_count_r <= '0;
      checksum_r   <= 32'h0000_0000;
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            word_count_r <= '0;
            checksum_r   <= 32'h0000_0000;
            byte_cnt_r   <= 2'd0;
            in_ready_r   <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_s) begin
            word_r     <= {word_r[15:0], bus.in_data};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= word_count_r;
              mem_wdata_r <= {word_r, bus.in_data};
            end
          end
          // count and checksum advance at the end of the write cycle
          if (mem_we_r) begin
            word_count_r <= word_count_r + ADDR_W'(1);
            checksum_r   <= checksum_r + mem_wdata_r;
          end
          if (last_wr_s) begin
            in_ready_r  <= 1'b0;
            load_done_r <= 1'b1;
            cpu_rstn_r  <= 1'b1;
          end
        end
        RUN: begin
          if (cpu_done) run_done_r <= 1'b1;
        end
        DONE: begin
          run_done_r <= 1'b1;
        end
        default: begin
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_rstn      = cpu_rstn_r;
  assign load_done     = load_done_r;
  assign run_done      = run_done_r;
  assign word_count    = word_count_r;
  assign checksum      = checksum_r;

endmodule

// File: tb/tb_dmem_loader.sv
// Directed bench for dmem_loader: a 2-word instance for timing/handshake detail and a
// default-size instance for the full 5100-word image and mid-load reset.
module tb_dmem_loader;

  localparam int L_WORDS = 5100;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_start, l_start;
  logic        s_cpu_done, l_cpu_done;
  logic        s_cpu_rstn, l_cpu_rstn;
  logic        s_load_done, l_load_done;
  logic        s_run_done, l_run_done;
  logic [15:0] s_wc, l_wc;
  logic [31:0] s_sum, l_sum;

  int errors = 0;
  int checks = 0;
  int mon_idx = 0;
  int mon_bad = 0;

  dmem_loader_if #(.ADDR_W(16)) s_if ();
  dmem_loader_if #(.ADDR_W(16)) l_if ();

  dmem_loader #(.M(1), .N(1), .N2(1), .ADDR_W(16)) dut_s (
    .CLOCK_50(clk), .rst(rst), .start(s_start), .bus(s_if.slave),
    .cpu_rstn(s_cpu_rstn), .cpu_done(s_cpu_done), .load_done(s_load_done),
    .run_done(s_run_done), .word_count(s_wc), .checksum(s_sum)
  );

  dmem_loader #(.M(100), .N(50), .N2(2), .ADDR_W(16)) dut_l (
    .CLOCK_50(clk), .rst(rst), .start(l_start), .bus(l_if.slave),
    .cpu_rstn(l_cpu_rstn), .cpu_done(l_cpu_done), .load_done(l_load_done),
    .run_done(l_run_done), .word_count(l_wc), .checksum(l_sum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Image monitor for the large instance: every write must hit the next address with the image word
  always @(negedge clk) begin
    if (l_start) begin
      mon_idx <= 0;
    end else if (l_if.mem_we) begin
      if (l_if.mem_addr !== 16'(mon_idx) || l_if.mem_wdata !== pat(mon_idx) || mon_idx >= L_WORDS) begin
        mon_bad <= mon_bad + 1;
        $display("monitor: write %0d addr=%0d data=%h", mon_idx, l_if.mem_addr, l_if.mem_wdata);
      end
      mon_idx <= mon_idx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream image bytes into the large instance with randomly gapped in_valid
  task automatic feed_large(input int nbytes);
    int idx = 0;
    int guard = 0;
    logic [31:0] w;
    while (idx < nbytes && guard < 90000) begin
      w = pat(idx / 4);
      l_if.in_data  = w[31 - 8 * (idx % 4) -: 8];
      l_if.in_valid = 1'($urandom_range(0, 1));
      tick();
      if (l_if.in_valid) idx++;
      guard++;
    end
    l_if.in_valid = 1'b0;
    chk("feed_bytes", 32'(idx), 32'(nbytes));
  endtask

  initial begin
    logic [7:0]  bytes [8];
    logic [31:0] exp_sum;
    int          wait_cyc;

    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
    bytes[4] = 8'h9A; bytes[5] = 8'hBC; bytes[6] = 8'hDE; bytes[7] = 8'hF0;

    // reset with in_valid high on both instances
    rst = 1'b1; s_start = 1'b0; l_start = 1'b0; s_cpu_done = 1'b0; l_cpu_done = 1'b0;
    s_if.in_valid = 1'b1; s_if.in_data = 8'hAA;
    l_if.in_valid = 1'b1; l_if.in_data = 8'h55;
    tick(); tick();
    chk("rst_in_ready",  32'(s_if.in_ready), 32'd0);
    chk("rst_cpu_rstn",  32'(s_cpu_rstn), 32'd0);
    chk("rst_mem_we",    32'(s_if.mem_we), 32'd0);
    chk("rst_mem_addr",  32'(s_if.mem_addr), 32'd0);
    chk("rst_mem_wdata", s_if.mem_wdata, 32'd0);
    chk("rst_load_done", 32'(s_load_done), 32'd0);
    chk("rst_run_done",  32'(s_run_done), 32'd0);
    chk("rst_wc",        32'(s_wc), 32'd0);
    chk("rst_sum",       s_sum, 32'd0);
    chk("rst_l_ready",   32'(l_if.in_ready), 32'd0);
    rst = 1'b0;
    s_if.in_valid = 1'b0;
    l_if.in_valid = 1'b0;
    tick();
    chk("idle_in_ready", 32'(s_if.in_ready), 32'd0);

    // two-word load on the small instance, with a cpu_done pulse during LOAD
    s_start = 1'b1; tick(); s_start = 1'b0;
    chk("load_in_ready", 32'(s_if.in_ready), 32'd1);
    for (int j = 0; j < 8; j++) begin
      s_if.in_data  = bytes[j];
      s_if.in_valid = 1'b1;
      s_cpu_done    = (j == 2);
      tick();
      if (j == 3) begin
        chk("w0_we",    32'(s_if.mem_we), 32'd1);
        chk("w0_addr",  32'(s_if.mem_addr), 32'd0);
        chk("w0_data",  s_if.mem_wdata, 32'h1234_5678);
      end
      if (j == 4) begin
        chk("w0_we_1cyc", 32'(s_if.mem_we), 32'd0);
        chk("w0_hold",    s_if.mem_wdata, 32'h1234_5678);
        chk("w0_wc",      32'(s_wc), 32'd1);
      end
      if (j == 7) begin
        chk("w1_we",    32'(s_if.mem_we), 32'd1);
        chk("w1_addr",  32'(s_if.mem_addr), 32'd1);
        chk("w1_data",  s_if.mem_wdata, 32'h9ABC_DEF0);
        chk("w1_rstn",  32'(s_cpu_rstn), 32'd0);
        chk("w1_ldone", 32'(s_load_done), 32'd0);
      end
    end
    s_cpu_done = 1'b0;
    s_if.in_data = 8'h5A;
    tick();
    chk("run_we",    32'(s_if.mem_we), 32'd0);
    chk("run_ldone", 32'(s_load_done), 32'd1);
    chk("run_rstn",  32'(s_cpu_rstn), 32'd1);
    chk("run_ready", 32'(s_if.in_ready), 32'd0);
    chk("run_wc",    32'(s_wc), 32'd2);
    chk("run_sum",   s_sum, 32'hACF1_3568);
    repeat (3) tick();
    chk("run_ign_wc",  32'(s_wc), 32'd2);
    chk("run_ign_we",  32'(s_if.mem_we), 32'd0);
    chk("run_no_done", 32'(s_run_done), 32'd0);
    s_if.in_valid = 1'b0;

    // cpu_done in RUN, then start ignored in DONE
    s_cpu_done = 1'b1; tick(); s_cpu_done = 1'b0;
    chk("done_run_done", 32'(s_run_done), 32'd1);
    s_start = 1'b1; tick(); s_start = 1'b0;
    tick();
    chk("done_start_ready", 32'(s_if.in_ready), 32'd0);
    chk("done_start_rd",    32'(s_run_done), 32'd1);
    chk("done_start_wc",    32'(s_wc), 32'd2);
    chk("done_start_rstn",  32'(s_cpu_rstn), 32'd1);
    chk("done_start_sum",   s_sum, 32'hACF1_3568);

    // large instance: reset after 3 bytes of word 7
    l_start = 1'b1; tick(); l_start = 1'b0;
    feed_large(7 * 4 + 3);
    tick();
    chk("part_writes", 32'(mon_idx), 32'd7);
    chk("part_wc",     32'(l_wc), 32'd7);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_wc",    32'(l_wc), 32'd0);
    chk("abort_rstn",  32'(l_cpu_rstn), 32'd0);
    chk("abort_ready", 32'(l_if.in_ready), 32'd0);
    chk("abort_we",    32'(l_if.mem_we), 32'd0);
    chk("abort_s_rd",  32'(s_run_done), 32'd0);

    // full default image from address 0
    l_start = 1'b1; tick(); l_start = 1'b0;
    feed_large(L_WORDS * 4);
    wait_cyc = 0;
    while (!l_load_done && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    chk("full_ldone", 32'(l_load_done), 32'd1);
    exp_sum = 32'h0;
    for (int i = 0; i < L_WORDS; i++) exp_sum = exp_sum + pat(i);
    l_if.in_valid = 1'b1;
    l_cpu_done = 1'b0;
    repeat (6) tick();
    l_if.in_valid = 1'b0;
    chk("full_writes", 32'(mon_idx), 32'(L_WORDS));
    chk("full_bad",    32'(mon_bad), 32'd0);
    chk("full_wc",     32'(l_wc), 32'(L_WORDS));
    chk("full_sum",    l_sum, exp_sum);
    chk("full_rstn",   32'(l_cpu_rstn), 32'd1);
    chk("full_rd",     32'(l_run_done), 32'd0);
    l_cpu_done = 1'b1; tick(); l_cpu_done = 1'b0;
    chk("full_run_done", 32'(l_run_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
